// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Scan sequencer for a four-digit seven-segment clock display.
// It steps the digit select, generates the blink phase, and produces a
// per-digit blanking strobe. The strobe covers the ghost guard at the start
// of each digit period, blinking of the field being edited, and leading-zero
// suppression of the hours-tens digit.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active high
//   set_mode     in   [1:0] 00 normal, 01 edit minutes, 10 edit hours, 11 = 00
//   lz_en        in   enable leading-zero blanking of hours tens
//   hours_tens   in   [2:0] current hours-tens digit
//   sel          out  [1:0] digit select (0 = minutes units .. 3 = hours tens)
//   blink        out  blink phase (1 = colon dp off / edited field hidden)
//   digit_blank  out  1 = the digit selected by sel must be dark
//   scan_tick    out  one-cycle pulse in the cycle sel takes a new value
//
// Effective mode (registered copy of set_mode, 11 folded onto 00)
//   mode      | meaning
//   MODE_NORM | normal display, nothing blinks
//   MODE_MIN  | editing minutes, sel 0/1 hidden while blink = 1
//   MODE_HRS  | editing hours,   sel 2/3 hidden while blink = 1

module display_scan_ctrl #(
   parameter int SCAN_DIV  = 100000,
   parameter int GUARD     = 16,
   parameter int BLINK_DIV = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] set_mode,
   input  logic       lz_en,
   input  logic [2:0] hours_tens,
   output logic [1:0] sel,
   output logic       blink,
   output logic       digit_blank,
   output logic       scan_tick
);

   localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] GUARD_W    = SW'(GUARD);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   // With no guard the reset digit (sel 0, blink 0) is never dark.
   localparam logic          BLANK_RST  = (GUARD > 0);

   typedef enum logic [1:0] {
      MODE_NORM = 2'b00,
      MODE_MIN  = 2'b01,
      MODE_HRS  = 2'b10
   } mode_e;

   logic [SW-1:0] scnt_q, scnt_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [1:0]    sel_q, sel_d;
   logic          blink_q, blink_d;
   logic          blank_q, blank_d;
   logic          tick_q, tick_d;
   mode_e         mode_q, mode_d;

   logic          scan_term;
   logic          blink_term;
   logic          mode_chg;
   logic          edit_hide;

   always_comb begin
      mode_d     = (set_mode == 2'b11) ? MODE_NORM : mode_e'(set_mode);
      mode_chg   = (mode_d != mode_q);
      scan_term  = (scnt_q == SCAN_LAST);
      blink_term = (bcnt_q == BLINK_LAST);

      scnt_d = scan_term ? '0 : scnt_q + SW'(1);
      sel_d  = scan_term ? sel_q + 2'd1 : sel_q;
      tick_d = scan_term;

      // A mode change restarts the blink so the edited field shows at once;
      // it overrides a blink terminal count landing on the same edge.
      bcnt_d  = bcnt_q + BW'(1);
      blink_d = blink_q;
      if (mode_chg) begin
         bcnt_d  = '0;
         blink_d = 1'b0;
      end else if (blink_term) begin
         bcnt_d  = '0;
         blink_d = ~blink_q;
      end

      edit_hide = 1'b0;
      if (blink_d) begin
         case (mode_d)
            MODE_MIN: edit_hide = ~sel_d[1];
            MODE_HRS: edit_hide = sel_d[1];
            default:  edit_hide = 1'b0;
         endcase
      end

      // Built from next-state values so the registered strobe always
      // matches the sel value presented alongside it.
      blank_d = (scnt_d < GUARD_W) |
                edit_hide |
                (lz_en & (sel_d == 2'd3) & (hours_tens == 3'd0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scnt_q  <= '0;
         bcnt_q  <= '0;
         sel_q   <= 2'd0;
         blink_q <= 1'b0;
         blank_q <= BLANK_RST;
         tick_q  <= 1'b0;
         mode_q  <= MODE_NORM;
      end else begin
         scnt_q  <= scnt_d;
         bcnt_q  <= bcnt_d;
         sel_q   <= sel_d;
         blink_q <= blink_d;
         blank_q <= blank_d;
         tick_q  <= tick_d;
         mode_q  <= mode_d;
      end
   end

   assign sel         = sel_q;
   assign blink       = blink_q;
   assign digit_blank = blank_q;
   assign scan_tick   = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with SCAN_DIV=8, GUARD=2, BLINK_DIV=20.
// Cycle c counts clock edges since reset release; c=0 is the reset state.

module tb_display_scan_ctrl;

   localparam int SCAN_DIV  = 8;
   localparam int GUARD     = 2;
   localparam int BLINK_DIV = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] set_mode = 2'b00;
   logic       lz_en = 1'b0;
   logic [2:0] hours_tens = 3'd1;
   logic [1:0] sel;
   logic       blink;
   logic       digit_blank;
   logic       scan_tick;

   int n_tests = 0;
   int n_fail  = 0;

   display_scan_ctrl #(
      .SCAN_DIV (SCAN_DIV),
      .GUARD    (GUARD),
      .BLINK_DIV(BLINK_DIV)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .set_mode   (set_mode),
      .lz_en      (lz_en),
      .hours_tens (hours_tens),
      .sel        (sel),
      .blink      (blink),
      .digit_blank(digit_blank),
      .scan_tick  (scan_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] mode;
      logic       lz;
      logic [2:0] ht;
      int         n;
      logic [1:0] sel;
      logic       blink;
      logic       blank;
      logic       tick;
   } vec_t;

   vec_t vecs[26];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance n clock edges, leaving the bench at the following falling edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      set_mode = 2'b00;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int first_rise;
      int last_rise;
      int n_rise;
      int n_tog;
      logic prev_blink;

      //             mode  lz    ht    n   sel   blk   blank tick
      vecs[0]  = '{2'b00, 1'b0, 3'd1, 0,  2'd0, 1'b0, 1'b1, 1'b0}; // c=0 reset
      vecs[1]  = '{2'b00, 1'b0, 3'd1, 2,  2'd0, 1'b0, 1'b0, 1'b0}; // c=2 guard over
      vecs[2]  = '{2'b00, 1'b0, 3'd1, 6,  2'd1, 1'b0, 1'b1, 1'b1}; // c=8 step
      vecs[3]  = '{2'b00, 1'b0, 3'd1, 12, 2'd2, 1'b1, 1'b0, 1'b0}; // c=20 blink=1
      vecs[4]  = '{2'b01, 1'b0, 3'd1, 1,  2'd2, 1'b0, 1'b0, 1'b0}; // c=21 restart
      vecs[5]  = '{2'b01, 1'b0, 3'd1, 19, 2'd1, 1'b0, 1'b1, 1'b1}; // c=40
      vecs[6]  = '{2'b01, 1'b0, 3'd1, 3,  2'd1, 1'b1, 1'b1, 1'b0}; // c=43 min hidden
      vecs[7]  = '{2'b01, 1'b0, 3'd1, 7,  2'd2, 1'b1, 1'b0, 1'b0}; // c=50 hrs shown
      vecs[8]  = '{2'b01, 1'b0, 3'd1, 14, 2'd0, 1'b0, 1'b1, 1'b1}; // c=64 guard
      vecs[9]  = '{2'b01, 1'b0, 3'd1, 2,  2'd0, 1'b0, 1'b0, 1'b0}; // c=66
      vecs[10] = '{2'b01, 1'b0, 3'd1, 34, 2'd0, 1'b1, 1'b1, 1'b0}; // c=100
      vecs[11] = '{2'b10, 1'b0, 3'd1, 1,  2'd0, 1'b0, 1'b0, 1'b0}; // c=101 restart
      vecs[12] = '{2'b10, 1'b0, 3'd1, 24, 2'd3, 1'b1, 1'b1, 1'b0}; // c=125 hrs hidden
      vecs[13] = '{2'b10, 1'b0, 3'd1, 6,  2'd0, 1'b1, 1'b0, 1'b0}; // c=131 min shown
      vecs[14] = '{2'b11, 1'b0, 3'd1, 1,  2'd0, 1'b0, 1'b0, 1'b0}; // c=132 10->11 restart
      vecs[15] = '{2'b11, 1'b0, 3'd1, 23, 2'd3, 1'b1, 1'b0, 1'b0}; // c=155 no edit
      vecs[16] = '{2'b00, 1'b0, 3'd1, 1,  2'd3, 1'b1, 1'b0, 1'b0}; // c=156 11->00 no restart
      vecs[17] = '{2'b11, 1'b0, 3'd1, 3,  2'd3, 1'b1, 1'b0, 1'b0}; // c=159 00->11 no restart
      vecs[18] = '{2'b11, 1'b0, 3'd1, 13, 2'd1, 1'b0, 1'b0, 1'b0}; // c=172 toggle
      vecs[19] = '{2'b00, 1'b1, 3'd0, 12, 2'd3, 1'b0, 1'b1, 1'b1}; // c=184 lz sel3
      vecs[20] = '{2'b00, 1'b1, 3'd0, 4,  2'd3, 1'b0, 1'b1, 1'b0}; // c=188 lz mid
      vecs[21] = '{2'b00, 1'b1, 3'd0, 4,  2'd0, 1'b1, 1'b1, 1'b1}; // c=192
      vecs[22] = '{2'b00, 1'b1, 3'd0, 2,  2'd0, 1'b1, 1'b0, 1'b0}; // c=194 lz only sel3
      vecs[23] = '{2'b00, 1'b1, 3'd1, 22, 2'd3, 1'b0, 1'b1, 1'b1}; // c=216 guard
      vecs[24] = '{2'b00, 1'b1, 3'd1, 2,  2'd3, 1'b0, 1'b0, 1'b0}; // c=218 ht=1 shown
      vecs[25] = '{2'b00, 1'b0, 3'd0, 2,  2'd3, 1'b0, 1'b0, 1'b0}; // c=220 lz off

      // Free run in mode 00: cadence, guard, tick and blink period.
      lz_en = 1'b0;
      hours_tens = 3'd1;
      do_reset();
      first_rise = -1;
      last_rise  = -1;
      n_rise     = 0;
      n_tog      = 0;
      prev_blink = 1'b0;
      for (int c = 0; c <= 140; c++) begin
         if (c > 0) step(1);
         chk($sformatf("run c=%0d sel", c), 32'(sel), 32'((c / SCAN_DIV) % 4));
         chk($sformatf("run c=%0d tick", c), 32'(scan_tick),
             32'((c % SCAN_DIV == 0) && (c != 0)));
         chk($sformatf("run c=%0d blank", c), 32'(digit_blank), 32'((c % SCAN_DIV) < GUARD));
         chk($sformatf("run c=%0d blink", c), 32'(blink), 32'((c / BLINK_DIV) % 2));
         if (c > 0 && blink !== prev_blink) n_tog++;
         if (c > 0 && blink === 1'b1 && prev_blink === 1'b0) begin
            if (first_rise < 0) first_rise = c;
            last_rise = c;
            n_rise++;
         end
         prev_blink = blink;
      end
      chk("blink rises", 32'(n_rise), 32'd4);
      chk("blink toggles", 32'(n_tog), 32'd7);
      chk("blink period x3", 32'(last_rise - first_rise), 32'd120);

      // Directed table: edit modes, mode-11 folding, leading zero.
      do_reset();
      for (int i = 0; i < 26; i++) begin
         set_mode   = vecs[i].mode;
         lz_en      = vecs[i].lz;
         hours_tens = vecs[i].ht;
         step(vecs[i].n);
         chk($sformatf("vec%0d sel", i),   32'(sel),         32'(vecs[i].sel));
         chk($sformatf("vec%0d blink", i), 32'(blink),       32'(vecs[i].blink));
         chk($sformatf("vec%0d blank", i), 32'(digit_blank), 32'(vecs[i].blank));
         chk($sformatf("vec%0d tick", i),  32'(scan_tick),   32'(vecs[i].tick));
      end

      // Asynchronous reset mid-period with sel=2, blink=1.
      set_mode   = 2'b00;
      lz_en      = 1'b0;
      hours_tens = 3'd1;
      do_reset();
      step(20);
      chk("pre-rst sel", 32'(sel), 32'd2);
      chk("pre-rst blink", 32'(blink), 32'd1);
      chk("pre-rst blank", 32'(digit_blank), 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("async rst sel", 32'(sel), 32'd0);
      chk("async rst blink", 32'(blink), 32'd0);
      chk("async rst blank", 32'(digit_blank), 32'd1);
      chk("async rst tick", 32'(scan_tick), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c <= 17; c++) begin
         if (c > 0) step(1);
         chk($sformatf("post c=%0d sel", c), 32'(sel), 32'((c / SCAN_DIV) % 4));
         chk($sformatf("post c=%0d tick", c), 32'(scan_tick),
             32'((c % SCAN_DIV == 0) && (c != 0)));
         chk($sformatf("post c=%0d blank", c), 32'(digit_blank), 32'((c % SCAN_DIV) < GUARD));
         chk($sformatf("post c=%0d blink", c), 32'(blink), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Sequencing controller for the four-digit seven-segment display of the digital clock. It generates the digit-select sequence that drives the BCD/segment decoder, the blink phase used for the colon decimal point, and a per-digit blanking strobe. The strobe covers inter-digit ghost guarding, blinking of the field being edited in set mode, and leading-zero suppression of the hours-tens digit. It sits between the timekeeping core and the segment decoder; an outer gate forces all anodes high while `digit_blank` is 1.

## Interface
Parameters:
- `SCAN_DIV`, 100000: clock cycles each digit stays selected (≥ 2).
- `GUARD`, 16: cycles blanked at the start of each digit period (0 = disabled; must be < `SCAN_DIV`).
- `BLINK_DIV`, 50000000: clock cycles per blink half-period (≥ 2).

Ports:
- `clk`  in  1: system clock, all logic on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `set_mode`  in  2: 00 normal, 01 editing minutes, 10 editing hours, 11 treated as 00.
- `lz_en`  in  1: enable leading-zero blanking of hours tens.
- `hours_tens`  in  3: current hours-tens value from the timekeeping core.
- `sel`  out  2: digit select (0 = minutes units … 3 = hours tens).
- `blink`  out  1: blink phase; drives the decoder's colon clock (1 = dp off / field hidden).
- `digit_blank`  out  1: 1 = the digit currently selected by `sel` must be dark.
- `scan_tick`  out  1: one-cycle pulse in the cycle `sel` takes a new value.

## Operation
- All outputs are registered. Reset values: `sel`=0, `blink`=0, `digit_blank`=1 when `GUARD`>0 (else evaluated per the rules below for sel 0), `scan_tick`=0. Internal counters and the `set_mode` register are cleared to 0.
- Scan counter `scnt`:
  - Counts 0..`SCAN_DIV`-1.
  - At terminal it wraps to 0, `sel` increments modulo 4 (3→0), and `scan_tick` pulses in the same cycle `sel` changes.
- Blink counter `bcnt`:
  - Counts 0..`BLINK_DIV`-1.
  - At terminal it wraps and `blink` toggles.
- Edit restart: a change of the effective mode restarts blinking. Effective mode is `set_mode` with 11 mapped to 00. On the first clock edge where the effective mode differs from its registered copy, `bcnt` is cleared and `blink` is forced to 0, so the edited field is visible immediately. This has priority over a coincident blink terminal count.
- `digit_blank` is the OR of:
  - Guard: `scnt` < `GUARD`.
  - Edit: `blink`=1 and (mode 01 and `sel` ∈ {0,1}, or mode 10 and `sel` ∈ {2,3}).
  - Leading zero: `lz_en`=1, `sel`=3 and `hours_tens`=0.
- `digit_blank` is computed from next-state values, so it always refers to the `sel` value presented in the same cycle.
- `hours_tens` and `lz_en` are sampled each cycle; no synchronisation is required because they are in the `clk` domain.
- Scan and blink counters are independent; simultaneous terminal counts are both honoured in the same cycle.

## Timing
- Digit period: exactly `SCAN_DIV` cycles. A full frame is 4×`SCAN_DIV` cycles.
- Guard: the first `GUARD` cycles of every digit period, including the first period after reset, have `digit_blank`=1.
- `blink` period: 2×`BLINK_DIV` cycles, 50 % duty.
- Mode change latency: one cycle. The registered mode and the restart of `blink` appear on the edge after `set_mode` changes, and `digit_blank` follows in the same cycle.
- Reset asserted mid-frame returns all state to the reset values immediately, with no clock needed. Counting resumes on the first edge after deassertion.

## Test plan
Bench parameters: `SCAN_DIV`=8, `GUARD`=2, `BLINK_DIV`=20.
- Reset then free run in mode 00 with `lz_en`=0:
  - `sel` steps 0,1,2,3,0 every 8 cycles.
  - `scan_tick` pulses once per step.
  - `digit_blank`=1 for cycles 0–1 of each period and 0 for cycles 2–7.
- Blink: `blink` toggles every 20 cycles starting from 0 after reset; a 40-cycle period is measured over 3 periods.
- Edit minutes (mode 01) entered with `blink`=1:
  - Next cycle `blink`=0.
  - Afterwards, `digit_blank`=1 for the whole of `sel`=0/1 periods whenever `blink`=1.
  - `sel`=2/3 are blanked only during guard cycles.
- Mode 11 behaves exactly like 00. Switching 10→11 restarts blink; switching 00→11 does not.
- Leading zero: `lz_en`=1, `hours_tens`=0 → `sel`=3 fully blanked. With `hours_tens`=1, only the 2 guard cycles are blanked.
- Asynchronous reset pulse asserted mid-period with `sel`=2, `blink`=1:
  - All outputs return to reset values within the same cycle, without a clock edge.
  - After release, the 8-cycle cadence restarts from `sel`=0.
